hack_rom_arbiter: RTL and testbench
===================================

Name: hack_rom_arbiter

Overview:
Shares the single synchronous-read HackROM port between the CPU instruction-fetch path and a debug readback port (UART/JTAG memory dump). The CPU has priority. A starvation counter guarantees debug progress. The block tracks which requester owns each in-flight read through the ROM's fixed read latency and returns data only to that requester. It sits between the CPU, the debug bridge and the ROM.

Parameters:
ROM_LATENCY, 1, cycles from rom_address to valid rom_q (>=1)
MAX_WAIT, 8, consecutive denied debug-request cycles before debug is forced in (>=1, <=255)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
fetch_req  in  1  CPU requests a read this cycle
fetch_addr  in  15  CPU read address
fetch_gnt  out  1  combinational; fetch read issued this cycle
fetch_stall  out  1  fetch_req & ~fetch_gnt
fetch_data  out  16  rom_q passthrough
fetch_valid  out  1  fetch_data valid (response to a granted fetch)
dbg_req  in  1  debug requests a read
dbg_addr  in  15  debug read address
dbg_gnt  out  1  combinational; debug read issued this cycle
dbg_data  out  16  registered; holds the last debug result
dbg_valid  out  1  one-cycle pulse, dbg_data updated
rom_address  out  15  to ROM address
rom_q  in  16  from ROM q

Behaviour:
- Clocking: one clock; reset is synchronous and active-low.
- Grant, per cycle, combinational:
  - dbg_gnt = dbg_req & (~fetch_req | wait_cnt == MAX_WAIT).
  - fetch_gnt = fetch_req & ~dbg_gnt.
  - At most one grant per cycle.
- rom_address:
  - Address of the granted requester.
  - If there is no grant, hold last_addr (register, reset 0) to avoid needless toggling.
  - last_addr updates on every grant.
- wait_cnt (8-bit):
  - Increments when dbg_req & ~dbg_gnt, saturating at MAX_WAIT.
  - Clears to 0 on dbg_gnt or when dbg_req is low.
  - Reset 0.
- Owner pipeline:
  - ROM_LATENCY-deep shift register of {valid, owner}.
  - Stage 0 is loaded each cycle with {fetch_gnt|dbg_gnt, owner of grant}.
  - The final stage drives the responses.
  - All valid bits reset to 0.
- Responses:
  - fetch_valid = final.valid & owner==FETCH.
  - fetch_data = rom_q, unregistered.
  - When the final stage is valid with owner==DBG, rom_q is captured into dbg_data at the next edge and dbg_valid pulses for that cycle. Debug latency is therefore ROM_LATENCY+1.
- Back-to-back: one grant per cycle, sustained. A throughput of 1 read/cycle is required, no bubbles.
- Simultaneous requests:
  - Fetch wins unless wait_cnt==MAX_WAIT.
  - A forced debug grant stalls fetch exactly one cycle, after which wait_cnt=0.
- Requester dropping req: permitted at any time. Already-granted reads still complete and return.
- Reset mid-operation: in-flight reads are discarded, with no valid pulses after reset. Reset values:
  - fetch_valid=0, dbg_valid=0.
  - dbg_data=0, rom_address=0, wait_cnt=0.

Optional Feature:
HACK_ROM_ARB_STATS_EN.
- Defined:
  - Adds three 32-bit saturating counters, all reset 0: stats_fetch_cnt (fetch grants), stats_dbg_cnt (debug grants) and stats_forced_cnt (debug grants taken while fetch_req=1).
  - Each is exposed on an output port of the same name.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package hack_rom_pkg:
  - HACK_ADDR_W=15, HACK_DATA_W=16.
  - Owner encoding OWNER_FETCH=0, OWNER_DBG=1.
  - Stats counter width 32.
- Sub-module hack_rom_owner_pipe:
  - Parameterised ROM_LATENCY {valid,owner} shift register with synchronous active-low clear.
  - Reusable for any future ROM/RAM sharer.

Test Plan:
- Fetch only, addresses 0..9 on consecutive cycles, ROM word i = i+0x100 → fetch_valid high cycles 1..10, fetch_data 0x0100..0x0109 in order, fetch_stall never high.
- Debug only, dbg_addr=0x7FFF, ROM word=0xBEEF → dbg_gnt same cycle, dbg_valid pulse 2 cycles later, dbg_data=0xBEEF held until the next debug read.
- fetch_req held high continuously plus dbg_req high, MAX_WAIT=8 → dbg_gnt on the 9th cycle only, fetch_stall exactly that cycle, then wait_cnt=0 and the pattern repeats every 9 cycles.
- Alternating grants fetch@5, dbg@3, fetch@6 on successive cycles → fetch_valid/dbg_valid routed to the correct owner, no cross-delivery, fetch_data equals ROM[5] then ROM[6].
- reset_n low for 1 cycle with 1 fetch read in flight → no fetch_valid afterwards, rom_address=0, dbg_data=0, wait_cnt=0.
- With HACK_ROM_ARB_STATS_EN, the scenario-3 run of 27 cycles → stats_fetch_cnt=24, stats_dbg_cnt=3, stats_forced_cnt=3.

Source files
------------

// File: rtl/hack_rom_pkg.sv
// rtl/hack_rom_pkg.sv - shared widths, owner encoding and helpers for the HackROM arbiter
package hack_rom_pkg;

    localparam int HACK_ADDR_W = 15;
    localparam int HACK_DATA_W = 16;
    localparam int STATS_W     = 32;

    // Owner tag carried alongside each in-flight read
    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DBG   = 1'b1;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == {STATS_W{1'b1}}) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hack_rom_owner_pipe.sv
// rtl/hack_rom_owner_pipe.sv - {valid, owner} delay line matching a fixed memory read latency
module hack_rom_owner_pipe #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_valid,
    input  logic i_owner,
    output logic o_valid,
    output logic o_owner
);

    logic [LATENCY-1:0] r_valid;
    logic [LATENCY-1:0] r_owner;

    // Shift the grant tag one stage per cycle; clear drops every in-flight read
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= '0;
            r_owner <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_owner[0] <= i_owner;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_owner[i] <= r_owner[i-1];
            end
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_owner = r_owner[LATENCY-1];

endmodule

// File: rtl/hack_rom_arbiter.sv
// rtl/hack_rom_arbiter.sv - CPU/debug sharer of the HackROM read port (optional HACK_ROM_ARB_STATS_EN counters)
module hack_rom_arbiter
    import hack_rom_pkg::*;
#(
    parameter int ROM_LATENCY = 1,
    parameter int MAX_WAIT    = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fetch_req,
    input  logic [HACK_ADDR_W-1:0] fetch_addr,
    output logic                   fetch_gnt,
    output logic                   fetch_stall,
    output logic [HACK_DATA_W-1:0] fetch_data,
    output logic                   fetch_valid,
    input  logic                   dbg_req,
    input  logic [HACK_ADDR_W-1:0] dbg_addr,
    output logic                   dbg_gnt,
    output logic [HACK_DATA_W-1:0] dbg_data,
    output logic                   dbg_valid,
    output logic [HACK_ADDR_W-1:0] rom_address,
    input  logic [HACK_DATA_W-1:0] rom_q
`ifdef HACK_ROM_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]     stats_fetch_cnt,
    output logic [STATS_W-1:0]     stats_dbg_cnt,
    output logic [STATS_W-1:0]     stats_forced_cnt
`endif
);

    localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

    logic [7:0]             r_wait_cnt;
    logic [HACK_ADDR_W-1:0] r_last_addr;
    logic [HACK_DATA_W-1:0] r_dbg_data;
    logic                   r_dbg_valid;

    logic w_wait_full;
    logic w_dbg_gnt;
    logic w_fetch_gnt;
    logic w_any_gnt;
    logic w_fin_valid;
    logic w_fin_owner;
    logic w_fin_dbg;

    // CPU wins by default; a debug requester that has waited MAX_WAIT cycles takes one slot
    assign w_wait_full = (r_wait_cnt == C_MAX_WAIT);
    assign w_dbg_gnt   = dbg_req & (~fetch_req | w_wait_full);
    assign w_fetch_gnt = fetch_req & ~w_dbg_gnt;
    assign w_any_gnt   = w_fetch_gnt | w_dbg_gnt;

    assign dbg_gnt     = w_dbg_gnt;
    assign fetch_gnt   = w_fetch_gnt;
    assign fetch_stall = fetch_req & ~w_fetch_gnt;

    // Idle cycles replay the previous address so the ROM bus does not toggle
    assign rom_address = w_dbg_gnt   ? dbg_addr   :
                         w_fetch_gnt ? fetch_addr : r_last_addr;

    // Remember the most recently issued address
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_addr <= '0;
        end else if (w_any_gnt) begin
            r_last_addr <= rom_address;
        end
    end

    // Count consecutive denied debug cycles; any gap or grant restarts the count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (!dbg_req || w_dbg_gnt) begin
            r_wait_cnt <= '0;
        end else if (!w_wait_full) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    hack_rom_owner_pipe #(
        .LATENCY (ROM_LATENCY)
    ) u_owner_pipe (
        .clk     (clk),
        .resetn  (reset_n),
        .i_valid (w_any_gnt),
        .i_owner (w_dbg_gnt ? OWNER_DBG : OWNER_FETCH),
        .o_valid (w_fin_valid),
        .o_owner (w_fin_owner)
    );

    // Fetch data is a straight passthrough; only the owner tag decides who sees it
    assign fetch_valid = w_fin_valid & (w_fin_owner == OWNER_FETCH);
    assign fetch_data  = rom_q;
    assign w_fin_dbg   = w_fin_valid & (w_fin_owner == OWNER_DBG);

    // Debug result is registered and held until the next debug read returns
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dbg_data  <= '0;
            r_dbg_valid <= 1'b0;
        end else begin
            r_dbg_valid <= w_fin_dbg;
            if (w_fin_dbg) begin
                r_dbg_data <= rom_q;
            end
        end
    end

    assign dbg_data  = r_dbg_data;
    assign dbg_valid = r_dbg_valid;

`ifdef HACK_ROM_ARB_STATS_EN
    logic [STATS_W-1:0] r_stats_fetch;
    logic [STATS_W-1:0] r_stats_dbg;
    logic [STATS_W-1:0] r_stats_forced;

    // Saturating grant counters; a forced grant is a debug grant taken over a live fetch
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stats_fetch  <= '0;
            r_stats_dbg    <= '0;
            r_stats_forced <= '0;
        end else begin
            if (w_fetch_gnt) begin
                r_stats_fetch <= sat_inc(r_stats_fetch);
            end
            if (w_dbg_gnt) begin
                r_stats_dbg <= sat_inc(r_stats_dbg);
            end
            if (w_dbg_gnt && fetch_req) begin
                r_stats_forced <= sat_inc(r_stats_forced);
            end
        end
    end

    assign stats_fetch_cnt  = r_stats_fetch;
    assign stats_dbg_cnt    = r_stats_dbg;
    assign stats_forced_cnt = r_stats_forced;
`endif

endmodule

// File: tb/tb_hack_rom_arbiter.sv
// tb/tb_hack_rom_arbiter.sv - scoreboard bench for hack_rom_arbiter
module tb_hack_rom_arbiter;
    import hack_rom_pkg::*;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_req;
    logic [14:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_stall;
    logic [15:0] fetch_data;
    logic        fetch_valid;
    logic        dbg_req;
    logic [14:0] dbg_addr;
    logic        dbg_gnt;
    logic [15:0] dbg_data;
    logic        dbg_valid;
    logic [14:0] rom_address;
    logic [15:0] rom_q;
`ifdef HACK_ROM_ARB_STATS_EN
    logic [31:0] stats_fetch_cnt;
    logic [31:0] stats_dbg_cnt;
    logic [31:0] stats_forced_cnt;
`endif

    always #5 clk = ~clk;

    hack_rom_arbiter #(
        .ROM_LATENCY (1),
        .MAX_WAIT    (MAX_WAIT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .fetch_req        (fetch_req),
        .fetch_addr       (fetch_addr),
        .fetch_gnt        (fetch_gnt),
        .fetch_stall      (fetch_stall),
        .fetch_data       (fetch_data),
        .fetch_valid      (fetch_valid),
        .dbg_req          (dbg_req),
        .dbg_addr         (dbg_addr),
        .dbg_gnt          (dbg_gnt),
        .dbg_data         (dbg_data),
        .dbg_valid        (dbg_valid),
        .rom_address      (rom_address),
        .rom_q            (rom_q)
`ifdef HACK_ROM_ARB_STATS_EN
        ,
        .stats_fetch_cnt  (stats_fetch_cnt),
        .stats_dbg_cnt    (stats_dbg_cnt),
        .stats_forced_cnt (stats_forced_cnt)
`endif
    );

    function automatic logic [15:0] rom_word(input logic [14:0] a);
        if (a == 15'h7FFF) return 16'hBEEF;
        return 16'h0100 + {1'b0, a};
    endfunction

    // Single-cycle synchronous ROM
    always @(posedge clk) rom_q <= rom_word(rom_address);

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t fq[$];
    exp_t dq[$];

    int          m_wait = 0;
    logic [14:0] m_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Monitor: every response must match the oldest expectation, on its due cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n === 1'b1) begin
            if (fetch_valid === 1'b1) begin
                if (fq.size() == 0) chk("fetch_valid_unexpected", {31'd0, fetch_valid}, 32'd0);
                else begin
                    e = fq.pop_front();
                    chk("fetch_data", {16'd0, fetch_data}, {16'd0, e.data});
                    chk("fetch_latency", cyc_n, e.due);
                end
            end else if (fq.size() > 0 && fq[0].due <= cyc_n) begin
                void'(fq.pop_front());
                chk("fetch_valid_missing", {31'd0, fetch_valid}, 32'd1);
            end
            if (dbg_valid === 1'b1) begin
                if (dq.size() == 0) chk("dbg_valid_unexpected", {31'd0, dbg_valid}, 32'd0);
                else begin
                    e = dq.pop_front();
                    chk("dbg_data", {16'd0, dbg_data}, {16'd0, e.data});
                    chk("dbg_latency", cyc_n, e.due);
                end
            end else if (dq.size() > 0 && dq[0].due <= cyc_n) begin
                void'(dq.pop_front());
                chk("dbg_valid_missing", {31'd0, dbg_valid}, 32'd1);
            end
        end
    end

    task automatic cyc(input logic fr, input logic [14:0] fa, input logic dr, input logic [14:0] da);
        logic        eg_d;
        logic        eg_f;
        logic [14:0] ea;
        exp_t        e;
        @(posedge clk);
        #1;
        fetch_req  = fr;
        fetch_addr = fa;
        dbg_req    = dr;
        dbg_addr   = da;
        eg_d = dr & (!fr | (m_wait == MAX_WAIT));
        eg_f = fr & !eg_d;
        ea   = eg_d ? da : (eg_f ? fa : m_last);
        if (eg_f) begin
            e.data = rom_word(fa);
            e.due  = cyc_n + 1;
            fq.push_back(e);
        end
        if (eg_d) begin
            e.data = rom_word(da);
            e.due  = cyc_n + 2;
            dq.push_back(e);
        end
        @(negedge clk);
        chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, eg_d});
        chk("fetch_gnt", {31'd0, fetch_gnt}, {31'd0, eg_f});
        chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, fr & !eg_f});
        chk("rom_address", {17'd0, rom_address}, {17'd0, ea});
        if (dr && !eg_d) m_wait = (m_wait == MAX_WAIT) ? m_wait : m_wait + 1;
        else m_wait = 0;
        if (eg_f | eg_d) m_last = ea;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n    = 1'b0;
        fetch_req  = 1'b0;
        dbg_req    = 1'b0;
        fetch_addr = '0;
        dbg_addr   = '0;
        fq.delete();
        dq.delete();
        m_wait = 0;
        m_last = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_rom_address", {17'd0, rom_address}, 32'd0);
        chk("rst_dbg_data", {16'd0, dbg_data}, 32'd0);
        chk("rst_dbg_valid", {31'd0, dbg_valid}, 32'd0);
        chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_wait_cnt", {24'd0, dut.r_wait_cnt}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset_n    = 1'b0;
        fetch_req  = 1'b0;
        dbg_req    = 1'b0;
        fetch_addr = '0;
        dbg_addr   = '0;
        do_reset();

        // Fetch-only streaming, one read per cycle
        for (int i = 0; i < 10; i++) cyc(1'b1, 15'(i), 1'b0, 15'd0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 15'd0, 1'b0, 15'd0);

        // Debug-only read of the top word, then result must hold
        cyc(1'b0, 15'd0, 1'b1, 15'h7FFF);
        for (int i = 0; i < 4; i++) cyc(1'b0, 15'd0, 1'b0, 15'd0);
        chk("dbg_data_hold", {16'd0, dbg_data}, 32'h0000BEEF);

        // Interleaved owners: fetch@5, dbg@3, fetch@6
        cyc(1'b1, 15'd5, 1'b0, 15'd0);
        cyc(1'b0, 15'd0, 1'b1, 15'd3);
        cyc(1'b1, 15'd6, 1'b0, 15'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 15'd0, 1'b0, 15'd0);
        chk("dbg_data_interleave", {16'd0, dbg_data}, 32'h00000103);

        // Reset with a fetch in flight: nothing may come back
        cyc(1'b1, 15'd9, 1'b0, 15'd0);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 15'd0, 1'b0, 15'd0);

        // Sustained contention: debug forced in every 9th cycle
        for (int k = 0; k < 27; k++) begin
            cyc(1'b1, 15'(k), 1'b1, 15'h7FFF);
            chk("s3_dbg_pattern", {31'd0, dbg_gnt}, (k % 9 == 8) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 15'd0, 1'b0, 15'd0);

`ifdef HACK_ROM_ARB_STATS_EN
        chk("stats_fetch_cnt", stats_fetch_cnt, 32'd24);
        chk("stats_dbg_cnt", stats_dbg_cnt, 32'd3);
        chk("stats_forced_cnt", stats_forced_cnt, 32'd3);
`endif

        chk("fetch_queue_drained", fq.size(), 32'd0);
        chk("dbg_queue_drained", dq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
